// File: rtl/phy_pkg.sv
// Shared PHY definitions: frame geometry, the comma byte and the link state encoding.
// Used by both the transmit and receive sides.
package phy_pkg;

    localparam int unsigned LANES   = 4;
    localparam int unsigned BYTE_W  = 8;
    localparam int unsigned FRAME_W = LANES * BYTE_W;

    localparam logic [BYTE_W-1:0] COMMA = 8'hBC;

    typedef enum logic {
        SYNC,
        DATA
    } phy_state_e;

    // A lane slot carries its data only when the lane is being sampled and is valid.
    function automatic logic [BYTE_W-1:0] lane_byte(input logic take, input logic valid,
                                                    input logic [BYTE_W-1:0] data);
        return (take && valid) ? data : COMMA;
    endfunction

endpackage

// File: rtl/phy_tx_if.sv
// Upstream-facing lane bundle of the PHY transmitter plus its serial output and status.
// The upstream producer is the master; phy_tx is the slave.
interface phy_tx_if;
    import phy_pkg::*;

    logic [BYTE_W-1:0] in0;
    logic [BYTE_W-1:0] in1;
    logic [BYTE_W-1:0] in2;
    logic [BYTE_W-1:0] in3;
    logic              valid_in0;
    logic              valid_in1;
    logic              valid_in2;
    logic              valid_in3;
    logic              data_out;
    logic              load;
    logic              active;

    modport master (
        output in0, in1, in2, in3,
        output valid_in0, valid_in1, valid_in2, valid_in3,
        input  data_out, load, active
    );

    modport slave (
        input  in0, in1, in2, in3,
        input  valid_in0, valid_in1, valid_in2, valid_in3,
        output data_out, load, active
    );

endinterface

// File: rtl/paralelo_serial_tx.sv
// 32-bit parallel-in serial-out register: loads a whole frame or shifts left, MSB first.
// The serial output is registered from the top bit of the shift register.
module paralelo_serial_tx
    import phy_pkg::*;
(
    input  logic               clk_32f,
    input  logic               reset,
    input  logic               load,
    input  logic [FRAME_W-1:0] frame,
    output logic               data_out
);

    logic [FRAME_W-1:0] sr_q;

    always_ff @(posedge clk_32f or posedge reset) begin
        if (reset) begin
            sr_q     <= {LANES{COMMA}};
            data_out <= 1'b0;
        end else begin
            data_out <= sr_q[FRAME_W-1];
            if (load) begin
                sr_q <= frame;
            end else begin
                sr_q <= {sr_q[FRAME_W-2:0], 1'b0};
            end
        end
    end

endmodule

// File: rtl/phy_tx.sv
// PHY transmitter: sends comma frames after reset for far-end lock, then one sampled
// four-lane frame every 32 bit clocks with invalid lanes replaced by the comma.
module phy_tx
    import phy_pkg::*;
#(
    parameter int unsigned SYNC_FRAMES = 2
) (
    input  logic    clk_32f,
    input  logic    reset,
    phy_tx_if.slave bus
);

    localparam int unsigned    SW        = $clog2(SYNC_FRAMES) + 1;
    localparam logic [SW-1:0]  SYNC_LAST = SW'(SYNC_FRAMES - 1);
    localparam logic [4:0]     BIT_LAST  = 5'(FRAME_W - 1);

    phy_state_e         state_q, state_d;
    logic [SW-1:0]      sync_cnt_q, sync_cnt_d;
    logic [4:0]         bit_cnt_q;
    logic               frame_end;
    logic               take;
    logic [FRAME_W-1:0] frame;

    assign frame_end = (bit_cnt_q == BIT_LAST);

    always_ff @(posedge clk_32f or posedge reset) begin
        if (reset) begin
            state_q    <= SYNC;
            sync_cnt_q <= '0;
            bit_cnt_q  <= '0;
        end else begin
            state_q    <= state_d;
            sync_cnt_q <= sync_cnt_d;
            bit_cnt_q  <= bit_cnt_q + 5'd1;
        end
    end

    // sync_cnt only advances in SYNC, so it holds at SYNC_LAST once data flows.
    always_comb begin
        state_d    = state_q;
        sync_cnt_d = sync_cnt_q;
        take       = 1'b0;
        if (frame_end) begin
            case (state_q)
                SYNC: begin
                    if (sync_cnt_q == SYNC_LAST) begin
                        take    = 1'b1;
                        state_d = DATA;
                    end else begin
                        sync_cnt_d = sync_cnt_q + SW'(1);
                    end
                end
                DATA:    take = 1'b1;
                default: state_d = SYNC;
            endcase
        end
    end

    assign frame = {lane_byte(take, bus.valid_in0, bus.in0),
                    lane_byte(take, bus.valid_in1, bus.in1),
                    lane_byte(take, bus.valid_in2, bus.in2),
                    lane_byte(take, bus.valid_in3, bus.in3)};

    assign bus.load   = take;
    assign bus.active = (state_q == DATA);

    paralelo_serial_tx u_piso (
        .clk_32f  (clk_32f),
        .reset    (reset),
        .load     (frame_end),
        .frame    (frame),
        .data_out (bus.data_out)
    );

endmodule

// File: tb/tb_phy_tx.sv
// Directed bench for phy_tx: sync sequence, lane framing, comma substitution, sampling
// window, asynchronous reset mid-frame, and the single-sync-frame configuration.
module tb_phy_tx;

    logic clk_32f = 1'b0;
    logic reset   = 1'b1;
    int   checks  = 0;
    int   errors  = 0;

    always #5 clk_32f = ~clk_32f;

    phy_tx_if bus0 ();
    phy_tx_if bus1 ();

    phy_tx #(.SYNC_FRAMES(2)) dut0 (
        .clk_32f (clk_32f),
        .reset   (reset),
        .bus     (bus0)
    );

    phy_tx #(.SYNC_FRAMES(1)) dut1 (
        .clk_32f (clk_32f),
        .reset   (reset),
        .bus     (bus1)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic set_lanes0(input logic [7:0] d0, input logic [7:0] d1, input logic [7:0] d2,
                              input logic [7:0] d3, input logic [3:0] v);
        bus0.in0 = d0; bus0.in1 = d1; bus0.in2 = d2; bus0.in3 = d3;
        {bus0.valid_in0, bus0.valid_in1, bus0.valid_in2, bus0.valid_in3} = v;
    endtask

    // Advance n edges, sampling 1 time unit after each; optionally scramble dut0 inputs.
    task automatic get_bits(input int n, input bit toggle, output logic [31:0] b0,
                            output logic [31:0] b1, output int lc0);
        b0  = '0;
        b1  = '0;
        lc0 = 0;
        for (int i = 0; i < n; i++) begin
            @(posedge clk_32f);
            #1;
            b0 = {b0[30:0], bus0.data_out};
            b1 = {b1[30:0], bus1.data_out};
            if (bus0.load) lc0++;
            if (toggle) begin
                set_lanes0(8'($urandom), 8'($urandom), 8'($urandom), 8'($urandom),
                           4'($urandom_range(0, 15)));
            end
        end
    endtask

    initial begin
        logic [31:0] a0, a1, c0, c1;
        int          la, lc;

        set_lanes0(8'h00, 8'h00, 8'h00, 8'h00, 4'b0000);
        bus1.in0 = 8'h12; bus1.in1 = 8'h34; bus1.in2 = 8'h56; bus1.in3 = 8'h78;
        {bus1.valid_in0, bus1.valid_in1, bus1.valid_in2, bus1.valid_in3} = 4'b1111;

        #12;
        check("rst_data_out", 32'(bus0.data_out), 32'd0);
        check("rst_load",     32'(bus0.load),     32'd0);
        check("rst_active",   32'(bus0.active),   32'd0);
        @(negedge clk_32f);
        reset = 1'b0;

        // Edges 1..32: reset frame on both instances
        get_bits(31, 0, a0, a1, la);
        check("sf1_load_e31",   32'(bus1.load),   32'd1);
        check("sf1_active_e31", 32'(bus1.active), 32'd0);
        check("sf2_load_cnt_f0", 32'(la), 32'd0);
        get_bits(1, 0, c0, c1, lc);
        check("sf2_frame0", {a0[30:0], c0[0]}, 32'hBCBCBCBC);
        check("sf1_frame0", {a1[30:0], c1[0]}, 32'hBCBCBCBC);
        check("sf1_active_e32", 32'(bus1.active), 32'd1);
        check("sf2_active_e32", 32'(bus0.active), 32'd0);

        // Edges 33..64: second comma frame; lanes presented for sampling at edge 64
        set_lanes0(8'h11, 8'h22, 8'h33, 8'h44, 4'b1111);
        get_bits(31, 0, a0, a1, la);
        check("sf2_load_e63",   32'(bus0.load),   32'd1);
        check("sf2_active_e63", 32'(bus0.active), 32'd0);
        check("sf2_load_cnt_f1", 32'(la), 32'd1);
        get_bits(1, 0, c0, c1, lc);
        check("sf2_frame1", {a0[30:0], c0[0]}, 32'hBCBCBCBC);
        check("sf1_data_frame", {a1[30:0], c1[0]}, 32'h12345678);
        check("sf2_active_e64", 32'(bus0.active), 32'd1);
        check("sf2_load_e64",   32'(bus0.load),   32'd0);

        // Edges 65..96: first data frame; next lanes mix valid and invalid slots
        set_lanes0(8'hFF, 8'hFF, 8'hA5, 8'hFF, 4'b0010);
        get_bits(31, 0, a0, a1, la);
        check("data_load_e95", 32'(bus0.load), 32'd1);
        check("data_load_cnt", 32'(la), 32'd1);
        get_bits(1, 0, c0, c1, lc);
        check("frame_11223344", {a0[30:0], c0[0]}, 32'h11223344);

        // Edges 97..128: comma substitution frame while inputs churn every cycle
        get_bits(31, 1, a0, a1, la);
        set_lanes0(8'h5A, 8'hC3, 8'h0F, 8'h81, 4'b1101);
        get_bits(1, 1, c0, c1, lc);
        check("frame_bcbca5bc", {a0[30:0], c0[0]}, 32'hBCBCA5BC);

        // Edges 129..160: only the load-cycle values may appear
        get_bits(31, 1, a0, a1, la);
        set_lanes0(8'hFF, 8'hFF, 8'hFF, 8'hFF, 4'b1111);
        get_bits(1, 0, c0, c1, lc);
        check("frame_toggle", {a0[30:0], c0[0]}, 32'h5AC3BC81);

        // Reset after bit 13 of an all-ones data frame
        get_bits(13, 0, a0, a1, la);
        check("pre_rst_data_out", 32'(bus0.data_out), 32'd1);
        check("pre_rst_active",   32'(bus0.active),   32'd1);
        reset = 1'b1;
        #1;
        check("mid_rst_data_out", 32'(bus0.data_out), 32'd0);
        check("mid_rst_active",   32'(bus0.active),   32'd0);
        check("mid_rst_load",     32'(bus0.load),     32'd0);
        @(negedge clk_32f);
        @(negedge clk_32f);
        reset = 1'b0;

        get_bits(32, 0, a0, a1, la);
        check("re_frame0", a0, 32'hBCBCBCBC);
        check("re_load_cnt_f0", 32'(la), 32'd0);
        get_bits(31, 0, a0, a1, la);
        check("re_load_e63", 32'(bus0.load), 32'd1);
        check("re_load_cnt_f1", 32'(la), 32'd1);
        check("re_active_e63", 32'(bus0.active), 32'd0);
        get_bits(1, 0, c0, c1, lc);
        check("re_frame1", {a0[30:0], c0[0]}, 32'hBCBCBCBC);
        check("re_active_e64", 32'(bus0.active), 32'd1);
        get_bits(32, 0, a0, a1, la);
        check("re_data_frame", a0, 32'hFFFFFFFF);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
